pwm_dc_ramp: RTL and testbench
==============================

# pwm_dc_ramp

Duty-cycle slew generator that sits directly upstream of the PWM timer and drives its external duty-cycle inputs (i_DC / i_DC_valid). It accepts a target duty value over a valid/ready handshake and moves its output toward that target in fixed steps. A step is taken only on a qualified tick: every (i_tick_div+1)-th period-boundary strobe. This prevents abrupt duty jumps on motors, LEDs and other loads. It runs entirely in the PWM clock domain; any cross-domain inputs are synchronized before they reach this block.

## Interface
- DC_W, 16, width of duty, step and target values
- DIV_W, 8, width of tick prescaler
- clk  in  1  clock, same clock as the PWM counter
- rst  in  1  reset, asynchronous, active-high
- i_en  in  1  enable; when low, ramp freezes and targets are refused
- i_tgt  in  DC_W  target duty value
- i_tgt_valid  in  1  target offer
- o_tgt_ready  out  1  target accept; equals i_en
- i_step  in  DC_W  step size, sampled at each qualified tick
- i_tick  in  1  one-cycle period-boundary strobe from the PWM counter
- i_tick_div  in  DIV_W  prescaler: step on every (i_tick_div+1)-th i_tick
- o_dc  out  DC_W  current duty value; connects to i_DC
- o_dc_valid  out  1  one-cycle pulse when o_dc changes; connects to i_DC_valid
- o_busy  out  1  high while in RAMP
- o_done  out  1  one-cycle pulse when o_dc reaches the target

## Operation
- States:
  - IDLE: o_dc held, o_busy=0.
  - RAMP: o_busy=1.
- Accept rule: a target is accepted in any state when i_tgt_valid && o_tgt_ready. Accepting latches tgt_q and clears the prescaler count.
  - In IDLE, if i_tgt != o_dc: go to RAMP.
  - In IDLE, if i_tgt == o_dc: stay in IDLE, pulse o_done next cycle, no o_dc_valid.
  - In RAMP: retarget. tgt_q is replaced and the state stays RAMP, even if the new target equals o_dc. That case completes on the next qualified tick.
- Prescaler: cnt counts i_tick pulses while in RAMP and i_en=1. A qualified tick is an i_tick with cnt == i_tick_div. cnt then returns to 0; otherwise cnt increments. i_tick_div=0 qualifies every tick.
- Qualified tick in RAMP:
  - Compute diff = |tgt_q − o_dc| at DC_W+1 bits.
  - If i_step == 0 or diff <= i_step: o_dc ← tgt_q, pulse o_dc_valid (only if the value changed), pulse o_done, go to IDLE.
  - Else: o_dc ← o_dc ± i_step, moving toward tgt_q, and pulse o_dc_valid.
- No wrap-around is possible: the clamp-to-target rule bounds o_dc to [0, 2^DC_W−1].
- Simultaneous accept and qualified tick: the tick is evaluated against the old tgt_q. The new tgt_q and the prescaler clear take effect afterwards, so the following tick uses the new target.
- i_en low:
  - ticks are ignored and cnt is held;
  - state and o_dc are held;
  - o_tgt_ready=0.
- Reset mid-ramp: all state clears asynchronously and the ramp is abandoned.

## Timing
- Reset values: o_dc=0, o_dc_valid=0, o_busy=0, o_done=0, state=IDLE, cnt=0, tgt_q=0. o_tgt_ready follows i_en.
- o_dc, o_dc_valid and o_done are registered. They update 1 cycle after the qualifying i_tick cycle.
- o_busy rises 1 cycle after an accept in IDLE. It falls in the same cycle o_done pulses.
- Minimum ramp duration is 1 qualified tick. A full-scale ramp takes ceil(diff/step) qualified ticks.
- No combinational path from i_tick or i_tgt to any output. The only combinational path is o_tgt_ready = i_en.

## Structure
- Shared package pwm_pkg holds:
  - DC_W default constant;
  - ramp state enum {IDLE, RAMP};
  - a function computing the absolute difference at DC_W+1 bits.
- One natural sub-module: pwm_tick_prescaler (cnt register, clear input, enable, qualified-tick output). It is reusable by the PWM timer's clock divider.

## Test plan
- Reset, then target 100, step 30, div 0, ticks every 10 cycles → o_dc 30, 60, 90, 100 with four o_dc_valid pulses; o_done with the last; o_busy low afterwards.
- Target 500 from 1000, step 200, div 2 → a step only on every 3rd i_tick: 800, 600, 500; o_done on the third qualified tick.
- Target equal to current o_dc (0) in IDLE → o_done 1 cycle after the accept; no o_dc_valid; o_busy stays 0.
- Mid-ramp retarget (at o_dc=60, ramping to 100) to 0, with the accept in the same cycle as a qualified tick → that tick moves 60→90 (old target); subsequent ticks move 90→60→30→0.
- i_en dropped for 5 ticks mid-ramp → o_dc and cnt frozen, o_tgt_ready=0, offered target ignored; the ramp resumes on re-enable.
- Boundary cases:
  - step=0 → jump to target on the first qualified tick;
  - target 0xFFFF, step 0x8000 from 0 → 0x8000, then 0xFFFF, no overflow;
  - async rst mid-ramp → all outputs 0 immediately.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty-cycle path.
package pwm_pkg;

   localparam int DC_W_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_e;

   // Width-agnostic |a-b|; callers zero-extend and cast the result to DC_W+1 bits.
   function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Tick prescaler: qual_o marks every (div_i+1)-th tick_i, combinational from tick_i.
// Count held while tick_i is gated off; clr_i wins over counting and restarts the count.
module pwm_tick_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             tick_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             qual_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   // >= rather than == so a divider lowered mid-count does not wait for a full wrap.
   assign qual_o = tick_i && (cnt_q >= div_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (qual_o) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_dc_ramp.sv
// Duty-cycle slew generator: steps o_dc toward an accepted target once per qualified tick.
// Outputs registered (1 cycle after the qualifying tick); o_tgt_ready = i_en, nothing else stalls.
module pwm_dc_ramp
   import pwm_pkg::*;
#(
   parameter int DC_W  = DC_W_DEF,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [DC_W-1:0]  i_tgt,
   input  logic             i_tgt_valid,
   output logic             o_tgt_ready,
   input  logic [DC_W-1:0]  i_step,
   input  logic             i_tick,
   input  logic [DIV_W-1:0] i_tick_div,
   output logic [DC_W-1:0]  o_dc,
   output logic             o_dc_valid,
   output logic             o_busy,
   output logic             o_done
);

   ramp_state_e     state_q;
   logic [DC_W-1:0] dc_q;
   logic [DC_W-1:0] dc_d;
   logic [DC_W-1:0] tgt_q;
   logic            dc_vld_q;
   logic            done_q;
   logic            accept;
   logic            tick_en;
   logic            qual;
   logic            finish;
   logic [DC_W:0]   diff;

   assign o_tgt_ready = i_en;
   assign accept      = i_tgt_valid && i_en;
   assign tick_en     = i_tick && i_en && (state_q == RAMP);

   pwm_tick_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .tick_i (tick_en),
      .div_i  (i_tick_div),
      .qual_o (qual)
   );

   always_comb begin
      diff   = (DC_W+1)'(abs_diff(32'(tgt_q), 32'(dc_q)));
      finish = (i_step == '0) || (diff <= {1'b0, i_step});
      dc_d   = dc_q;
      if (finish) begin
         dc_d = tgt_q;
      end else if (tgt_q > dc_q) begin
         dc_d = dc_q + i_step;
      end else begin
         dc_d = dc_q - i_step;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dc_q     <= '0;
         tgt_q    <= '0;
         dc_vld_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         dc_vld_q <= 1'b0;
         done_q   <= 1'b0;
         if (accept) begin
            tgt_q <= i_tgt;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (i_tgt != dc_q) begin
                     state_q <= RAMP;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RAMP: begin
               if (qual) begin
                  dc_q     <= dc_d;
                  dc_vld_q <= (dc_d != dc_q);
                  if (finish) begin
                     done_q <= 1'b1;
                     // A different target accepted on the finishing tick keeps the ramp going.
                     if (!(accept && (i_tgt != tgt_q))) begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_dc       = dc_q;
   assign o_dc_valid = dc_vld_q;
   assign o_done     = done_q;
   assign o_busy     = (state_q == RAMP);

endmodule

// File: tb/tb_pwm_dc_ramp.sv
// Self-checking bench for pwm_dc_ramp: vector table, corner sequences, randomized model compare.
module tb_pwm_dc_ramp;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_en;
   logic [15:0] i_tgt;
   logic        i_tgt_valid;
   logic        o_tgt_ready;
   logic [15:0] i_step;
   logic        i_tick;
   logic [7:0]  i_tick_div;
   logic [15:0] o_dc;
   logic        o_dc_valid;
   logic        o_busy;
   logic        o_done;

   pwm_dc_ramp dut (
      .clk         (clk),
      .rst         (rst),
      .i_en        (i_en),
      .i_tgt       (i_tgt),
      .i_tgt_valid (i_tgt_valid),
      .o_tgt_ready (o_tgt_ready),
      .i_step      (i_step),
      .i_tick      (i_tick),
      .i_tick_div  (i_tick_div),
      .o_dc        (o_dc),
      .o_dc_valid  (o_dc_valid),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        tv;
      logic [15:0] tgt;
      logic [15:0] step;
      logic        tick;
      logic [7:0]  div;
      logic [15:0] dc;
      logic        vld;
      logic        done;
      logic        busy;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: duty, target, tick count since accept, ramp-in-progress flag.
   int   m_dc, m_tgt, m_cnt;
   bit   m_busy, m_vld, m_done;

   function automatic vec_t mk(logic en, logic tv, logic [15:0] tgt, logic [15:0] step,
                               logic tick, logic [7:0] div, logic [15:0] dc,
                               logic vld, logic done, logic busy);
      vec_t v;
      v.en = en; v.tv = tv; v.tgt = tgt; v.step = step; v.tick = tick; v.div = div;
      v.dc = dc; v.vld = vld; v.done = done; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model(input vec_t v);
      bit was_busy;
      bit qual;
      int s;
      int nd;
      was_busy = m_busy;
      qual     = 1'b0;
      m_vld    = 1'b0;
      m_done   = 1'b0;
      if (m_busy && v.en && v.tick) begin
         qual  = (m_cnt == int'(v.div));
         m_cnt = qual ? 0 : m_cnt + 1;
      end
      if (qual) begin
         s = int'(v.step);
         if (s == 0) nd = m_tgt;
         else if (m_tgt > m_dc) nd = (m_dc + s > m_tgt) ? m_tgt : m_dc + s;
         else nd = (m_dc - s < m_tgt) ? m_tgt : m_dc - s;
         m_vld = (nd != m_dc);
         m_dc  = nd;
         if (m_dc == m_tgt) begin
            m_done = 1'b1;
            m_busy = 1'b0;
         end
      end
      if (v.en && v.tv) begin
         m_tgt = int'(v.tgt);
         m_cnt = 0;
         if (!was_busy) begin
            if (m_tgt != m_dc) m_busy = 1'b1;
            else m_done = 1'b1;
         end else if (!m_busy && m_tgt != m_dc) begin
            m_busy = 1'b1;
         end
      end
   endtask

   task automatic drive(input vec_t v);
      i_en        = v.en;
      i_tgt_valid = v.tv;
      i_tgt       = v.tgt;
      i_step      = v.step;
      i_tick      = v.tick;
      i_tick_div  = v.div;
      model(v);
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic en, input logic tv, input logic [15:0] tgt,
                     input logic [15:0] step, input logic tick, input logic [7:0] div);
      drive(mk(en, tv, tgt, step, tick, div, 16'd0, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic model_clear();
      m_dc = 0; m_tgt = 0; m_cnt = 0;
      m_busy = 1'b0; m_vld = 1'b0; m_done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_en = 1'b1; i_tgt_valid = 1'b0; i_tgt = '0; i_step = '0; i_tick = 1'b0; i_tick_div = '0;
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_dc"},    32'(o_dc),       32'(m_dc));
      chk({tag, "_vld"},   32'(o_dc_valid), 32'(m_vld));
      chk({tag, "_done"},  32'(o_done),     32'(m_done));
      chk({tag, "_busy"},  32'(o_busy),     32'(m_busy));
      chk({tag, "_ready"}, 32'(o_tgt_ready), 32'(i_en));
   endtask

   initial begin
      rst = 1'b1;
      i_en = 1'b1; i_tgt_valid = 1'b0; i_tgt = '0; i_step = '0; i_tick = 1'b0; i_tick_div = '0;
      model_clear();
      #12;
      chk("rst_dc",    32'(o_dc), 0);
      chk("rst_vld",   32'(o_dc_valid), 0);
      chk("rst_done",  32'(o_done), 0);
      chk("rst_busy",  32'(o_busy), 0);
      chk("rst_ready", 32'(o_tgt_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 0->100 step 30, equal-target accept, step=0 jump, clamp, then 1000->500 with div 2.
      tbl.push_back(mk(1, 1, 100,  30, 0, 0,    0, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0,  30, 1, 0,   30, 1, 0, 1));
      tbl.push_back(mk(1, 0,   0,  30, 0, 0,   30, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0,  30, 1, 0,   60, 1, 0, 1));
      tbl.push_back(mk(1, 0,   0,  30, 1, 0,   90, 1, 0, 1));
      tbl.push_back(mk(1, 0,   0,  30, 1, 0,  100, 1, 1, 0));
      tbl.push_back(mk(1, 0,   0,  30, 0, 0,  100, 0, 0, 0));
      tbl.push_back(mk(1, 1, 100,  30, 1, 0,  100, 0, 1, 0));
      tbl.push_back(mk(1, 0,   0,  30, 0, 0,  100, 0, 0, 0));
      tbl.push_back(mk(1, 1,   7,   0, 0, 0,  100, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0,   0, 1, 0,    7, 1, 1, 0));
      tbl.push_back(mk(1, 1, 1000, 16'hFFFF, 0, 0,    7, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 16'hFFFF, 1, 0, 1000, 1, 1, 0));
      tbl.push_back(mk(1, 1, 500, 200, 0, 2, 1000, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2, 1000, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2, 1000, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  800, 1, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 0, 2,  800, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  800, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  800, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  600, 1, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  600, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  600, 0, 0, 1));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  500, 1, 1, 0));
      tbl.push_back(mk(1, 0,   0, 200, 1, 2,  500, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         chk($sformatf("tbl%0d_dc", i),   32'(o_dc),       32'(tbl[i].dc));
         chk($sformatf("tbl%0d_vld", i),  32'(o_dc_valid), 32'(tbl[i].vld));
         chk($sformatf("tbl%0d_done", i), 32'(o_done),     32'(tbl[i].done));
         chk($sformatf("tbl%0d_busy", i), 32'(o_busy),     32'(tbl[i].busy));
      end

      // Retarget to 0 on the same cycle as a qualified tick: that tick still uses target 100.
      do_reset();
      go(1, 1, 100, 30, 0, 0);
      go(1, 0, 0, 30, 1, 0);
      go(1, 0, 0, 30, 1, 0);
      chk("rt_pre_dc", 32'(o_dc), 60);
      go(1, 1, 0, 30, 1, 0);
      chk("rt_old_dc", 32'(o_dc), 90);
      chk("rt_old_busy", 32'(o_busy), 1);
      go(1, 0, 0, 30, 1, 0);
      chk("rt_60", 32'(o_dc), 60);
      go(1, 0, 0, 30, 1, 0);
      chk("rt_30", 32'(o_dc), 30);
      go(1, 0, 0, 30, 1, 0);
      chk("rt_0", 32'(o_dc), 0);
      chk("rt_done", 32'(o_done), 1);
      chk("rt_busy", 32'(o_busy), 0);

      // Enable low for 5 ticks with a target offered: everything frozen, count kept.
      do_reset();
      go(1, 1, 100, 30, 0, 1);
      go(1, 0, 0, 30, 1, 1);
      go(1, 0, 0, 30, 1, 1);
      go(1, 0, 0, 30, 1, 1);
      chk("en_pre_dc", 32'(o_dc), 30);
      for (int k = 0; k < 5; k++) begin
         go(0, 1, 5, 30, 1, 1);
         chk($sformatf("en_off%0d_ready", k), 32'(o_tgt_ready), 0);
         chk($sformatf("en_off%0d_dc", k),    32'(o_dc), 30);
         chk($sformatf("en_off%0d_busy", k),  32'(o_busy), 1);
      end
      go(1, 0, 0, 30, 1, 1);
      chk("en_resume_dc", 32'(o_dc), 60);
      chk("en_resume_vld", 32'(o_dc_valid), 1);
      go(1, 0, 0, 30, 1, 1);
      go(1, 0, 0, 30, 1, 1);
      chk("en_tgt_kept", 32'(o_dc), 90);

      // Full-scale ramp with a half-scale step.
      do_reset();
      go(1, 1, 16'hFFFF, 16'h8000, 0, 0);
      go(1, 0, 0, 16'h8000, 1, 0);
      chk("fs_mid", 32'(o_dc), 32'h8000);
      chk("fs_mid_busy", 32'(o_busy), 1);
      go(1, 0, 0, 16'h8000, 1, 0);
      chk("fs_top", 32'(o_dc), 32'hFFFF);
      chk("fs_done", 32'(o_done), 1);

      // Target equal to the reset value.
      do_reset();
      go(1, 1, 0, 5, 0, 0);
      chk("eq_done", 32'(o_done), 1);
      chk("eq_vld", 32'(o_dc_valid), 0);
      chk("eq_busy", 32'(o_busy), 0);
      go(1, 0, 0, 5, 0, 0);
      chk("eq_done_pulse", 32'(o_done), 0);

      // Asynchronous reset between clock edges mid-ramp.
      do_reset();
      go(1, 1, 100, 30, 0, 0);
      go(1, 0, 0, 30, 1, 0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_dc", 32'(o_dc), 0);
      chk("arst_vld", 32'(o_dc_valid), 0);
      chk("arst_busy", 32'(o_busy), 0);
      chk("arst_done", 32'(o_done), 0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic against the reference model, one divider per segment.
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         for (int n = 0; n < 500; n++) begin
            logic        en, tv, tick;
            logic [15:0] tgt, step;
            int          r;
            en   = ($urandom % 10) != 0;
            tv   = ($urandom % 12) == 0;
            tick = ($urandom % 3) == 0;
            tgt  = ($urandom % 2) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            r    = $urandom % 4;
            step = (r == 0) ? 16'd0 : (r == 1) ? 16'($urandom_range(1, 50)) : 16'($urandom);
            go(en, tv, tgt, step, tick, 8'(seg));
            check_model($sformatf("rnd%0d_%0d", seg, n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
